// File: rtl/nmr_comparator.sv
// N-modular-redundant equality comparator.
// COPIES independent WIDTH-bit comparators are majority-voted into a registered result.
// A persistence FSM tells transient copy disagreements apart from permanent faults.
// eq_vec is the force point used by the fault-injection fabric.

// One redundant comparator copy. It is kept as its own hierarchy so the copies are not merged.
module nmr_eq_copy #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             eq_o
);

   assign eq_o = (a_i == b_i);

endmodule

module nmr_comparator #(
   parameter int WIDTH     = 8,
   parameter int COPIES    = 3,
   parameter int PERSIST   = 2,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 clear_err,
   output logic                 out_valid,
   output logic                 A_EQ_B,
   output logic                 error,
   output logic                 fault,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int VOTE_W = $clog2(COPIES + 1);
   localparam int RUN_W  = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;

   // A tie on an even COPIES count does not exceed HALF, so it votes "not equal".
   localparam logic [VOTE_W-1:0]    HALF      = VOTE_W'(COPIES / 2);
   localparam logic [VOTE_W-1:0]    ALL_VOTES = VOTE_W'(COPIES);
   localparam logic [RUN_W-1:0]     RUN_LIMIT = RUN_W'(PERSIST);
   localparam logic [RUN_W-1:0]     RUN_ONE   = RUN_W'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAULT   = 2'd2
   } state_e;

   // Number of copies reporting equality.
   function automatic logic [VOTE_W-1:0] popcount(input logic [COPIES-1:0] v);
      logic [VOTE_W-1:0] n;
      n = {VOTE_W{1'b0}};
      for (int i = 0; i < COPIES; i++) begin
         n = n + VOTE_W'(v[i]);
      end
      return n;
   endfunction

   (* keep = "true" *) logic [COPIES-1:0] eq_vec;

   for (genvar g = 0; g < COPIES; g++) begin : g_copy
      (* keep_hierarchy = "yes", dont_touch = "true" *)
      nmr_eq_copy #(.WIDTH(WIDTH)) u_copy (
         .a_i  (A),
         .b_i  (B),
         .eq_o (eq_vec[g])
      );
   end

   logic [VOTE_W-1:0]    votes_s;
   logic                 voted_eq_s;
   logic                 disagree_s;

   state_e               state_q, state_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic                 out_valid_q, out_valid_d;
   logic                 a_eq_b_q, a_eq_b_d;
   logic                 error_q, error_d;
   logic                 fault_q, fault_d;

   // Majority vote and disagreement detection over the copy outputs.
   always_comb begin
      votes_s    = popcount(eq_vec);
      voted_eq_s = (votes_s > HALF);
      disagree_s = (votes_s != {VOTE_W{1'b0}}) && (votes_s != ALL_VOTES);
   end

   // Next-state for result registers, disagreement counter and persistence FSM.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      err_count_d = err_count_q;
      out_valid_d = in_valid;
      a_eq_b_d    = a_eq_b_q;
      error_d     = error_q;

      // The compare result is always reported, even when clear_err wipes the history.
      if (in_valid) begin
         a_eq_b_d = voted_eq_s;
         error_d  = disagree_s;
      end else begin
         a_eq_b_d = a_eq_b_q;
         error_d  = error_q;
      end

      if (clear_err) begin
         state_d     = ST_OK;
         run_d       = {RUN_W{1'b0}};
         err_count_d = {ERR_CNT_W{1'b0}};
      end else if (in_valid) begin
         if (disagree_s && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + CNT_ONE;
         end else begin
            err_count_d = err_count_q;
         end

         case (state_q)
            ST_OK: begin
               if (disagree_s) begin
                  if (PERSIST == 1) begin
                     state_d = ST_FAULT;
                     run_d   = {RUN_W{1'b0}};
                  end else begin
                     state_d = ST_SUSPECT;
                     run_d   = RUN_ONE;
                  end
               end else begin
                  state_d = ST_OK;
                  run_d   = {RUN_W{1'b0}};
               end
            end
            ST_SUSPECT: begin
               if (disagree_s) begin
                  if ((run_q + RUN_ONE) >= RUN_LIMIT) begin
                     state_d = ST_FAULT;
                     run_d   = {RUN_W{1'b0}};
                  end else begin
                     state_d = ST_SUSPECT;
                     run_d   = run_q + RUN_ONE;
                  end
               end else begin
                  state_d = ST_OK;
                  run_d   = {RUN_W{1'b0}};
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
               run_d   = {RUN_W{1'b0}};
            end
            default: begin
               state_d = ST_OK;
               run_d   = {RUN_W{1'b0}};
            end
         endcase
      end else begin
         state_d     = state_q;
         run_d       = run_q;
         err_count_d = err_count_q;
      end

      fault_d = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OK;
         run_q       <= {RUN_W{1'b0}};
         err_count_q <= {ERR_CNT_W{1'b0}};
         out_valid_q <= 1'b0;
         a_eq_b_q    <= 1'b0;
         error_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         err_count_q <= err_count_d;
         out_valid_q <= out_valid_d;
         a_eq_b_q    <= a_eq_b_d;
         error_q     <= error_d;
         fault_q     <= fault_d;
      end
   end

   assign out_valid = out_valid_q;
   assign A_EQ_B    = a_eq_b_q;
   assign error     = error_q;
   assign fault     = fault_q;
   assign err_count = err_count_q;

endmodule
